stopwatch_bcd: RTL and testbench
================================

# stopwatch_bcd

Minute/second stopwatch that consumes the one-cycle `clk_enable` tick from the clock-enable generator, i.e. one tick per second at the 10 MHz `clk10` domain. Counts MM:SS in BCD under start/stop and clear controls and drives four active-low seven-segment displays. Sits directly downstream of the tick generator, upstream of the board's HEX pins.

## Interface
Parameters:
- `MIN_LIMIT`, default 59: highest minute value shown; legal range 1..99.

Ports:
- `clk10` in 1: system clock. The single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `clk_enable` in 1: one-cycle count tick from the upstream generator.
- `start_stop` in 1: debounced, level, active-high button; rising edge toggles run/pause.
- `clear` in 1: debounced, level, active-high; zeroes the count when not running.
- `sec_ones`, `sec_tens`, `min_ones`, `min_tens` out 4 each: registered BCD digits.
- `running` out 1: high in RUN.
- `rollover` out 1: one-cycle pulse on wrap MIN_LIMIT:59 -> 00:00.
- `hex0`..`hex3` out 7 each: active-low segments {g..a}. `hex0` is `sec_ones`; `hex3` is `min_tens`.

## Operation
- Edge detect: `start_stop` registered into `ss_q`; `ss_rise = start_stop & ~ss_q`.
- FSM states:
  - IDLE: reset state, count 00:00. `ss_rise` -> RUN.
  - RUN: `ss_rise` -> PAUSE.
  - PAUSE: `ss_rise` -> RUN. `clear` -> IDLE.
- `clear` in RUN is ignored. `clear` in IDLE holds 00:00.
- Counting happens only when the current (registered) state is RUN and `clk_enable`=1. Increment rules:
  - `sec_ones` 9 -> 0 with carry into `sec_tens`.
  - `sec_tens` 5 -> 0 with carry into the minutes.
  - Minutes count as a two-digit BCD value. A carry at `min_tens:min_ones` == MIN_LIMIT wraps all four digits to 0 and pulses `rollover`.
- Digits never take non-BCD values. No input can produce a value above MIN_LIMIT:59.
- `running` = (state == RUN).

## Timing
- Reset (`reset`=1 at an edge): state IDLE, `ss_q`=0, all digits 0, `running`=0, `rollover`=0. `hex0..3` = 7'b1000000 ("0"), or 7'h7F without the configuration macro.
- Tick latency: a tick sampled at edge N updates the digits, `rollover` and `hex*` visible after edge N.
- Start latency: an `ss_rise` sampled at edge N makes `running`=1 after edge N. A tick sampled at that same edge N is not counted; the first counted tick is at edge N+1 or later.
- Pause: a tick coincident with the `ss_rise` that leaves RUN is still counted, because state is RUN at that edge.
- `start_stop` held high produces exactly one toggle. It must go low and high again to toggle once more.
- Simultaneous `clear` and `ss_rise` in PAUSE: `ss_rise` wins (-> RUN, count kept); `clear` is ignored.
- `reset` has priority over everything, including mid-count and mid-rollover.
- `rollover` is high for exactly one cycle, the same cycle the digits show 00:00.

## Configuration
- `STOPWATCH_SEG7_EN` defined: the four seven-segment decoders are instantiated. Glyphs 0-9 use standard active-low encoding; codes 10-15 are never generated.
- `STOPWATCH_SEG7_EN` undefined: no decoders are built and `hex0..hex3` are constant 7'h7F (blank). BCD outputs, FSM and `rollover` are unchanged.

## Structure
- Shared package `stopwatch_pkg`:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2.
  - Segment constant for blank.
  - Seven-segment glyph table for 0-9.
- One sub-module, `seg7_decoder`: combinational, 4-bit BCD in, 7-bit active-low out. Instantiated four times under the macro.
- Top level contains the edge detect, FSM and BCD cascade.

## Test plan
- Reset, then 10 ticks with no start -> digits stay 00:00, `running`=0. `hex0`=7'b1000000 with the macro, 7'h7F without.
- Start pulse, then 61 ticks -> 01:01. `running`=1. `hex1`=7'b1000000, `hex0`=7'b1111001.
- Preload by ticking to MIN_LIMIT:59 (59:59), one more tick -> 00:00 with a single-cycle `rollover`.
- Start, 5 ticks, stop, 3 ticks -> 00:05 held. `clear` -> 00:00 and IDLE. `clear` asserted during RUN at 00:07 -> no effect.
- `ss_rise` coincident with a tick from IDLE -> 00:00 after that edge. Next tick -> 00:01.
- `start_stop` held high for 100 cycles with ticks -> exactly one toggle. `reset` mid-count at 00:42 -> 00:00, IDLE after the reset edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch: FSM state encoding,
// blank segment pattern and the active-low seven-segment glyph table.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; codes above 9 are never driven, so they blank.
    function automatic logic [6:0] seg7_glyph(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-low seven-segment decoder.
// Only compiled when STOPWATCH_SEG7_EN is defined; otherwise no decoder exists.
`ifdef STOPWATCH_SEG7_EN
module seg7_decoder
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = seg7_glyph(bcd);
    end

endmodule
`endif

// File: rtl/stopwatch_bcd.sv
// MM:SS BCD stopwatch with start/stop toggle, clear and rollover pulse.
// STOPWATCH_SEG7_EN builds the four display decoders; without it hex0..hex3 are blank.
//
// state | meaning
// IDLE  | count held at 00:00, waiting for start
// RUN   | counting on each clk_enable tick
// PAUSE | count frozen; clear returns to IDLE
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int MIN_LIMIT = 59
) (
    input  logic       clk10,
    input  logic       reset,
    input  logic       clk_enable,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       rollover,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3
);

    localparam logic [3:0] LIM_TENS = 4'(MIN_LIMIT / 10);
    localparam logic [3:0] LIM_ONES = 4'(MIN_LIMIT % 10);

    sw_state_t  state_q;
    sw_state_t  state_d;
    logic       ss_q;
    logic       ss_rise;
    logic       count_en;
    logic       zero_cnt;
    logic       wrap;
    logic [3:0] sec_ones_d;
    logic [3:0] sec_tens_d;
    logic [3:0] min_ones_d;
    logic [3:0] min_tens_d;

    assign ss_rise  = start_stop & ~ss_q;
    assign count_en = (state_q == RUN) & clk_enable;
    assign zero_cnt = (state_q == PAUSE) & (state_d == IDLE);
    assign running  = (state_q == RUN);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ss_rise) state_d = RUN;
            RUN:     if (ss_rise) state_d = PAUSE;
            PAUSE: begin
                if (ss_rise)    state_d = RUN;
                else if (clear) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Digit cascade: seconds carry into a two-digit minute value that wraps at MIN_LIMIT.
    always_comb begin
        sec_ones_d = sec_ones;
        sec_tens_d = sec_tens;
        min_ones_d = min_ones;
        min_tens_d = min_tens;
        wrap       = 1'b0;
        if (zero_cnt) begin
            sec_ones_d = 4'd0;
            sec_tens_d = 4'd0;
            min_ones_d = 4'd0;
            min_tens_d = 4'd0;
        end else if (count_en) begin
            if (sec_ones != 4'd9) begin
                sec_ones_d = sec_ones + 4'd1;
            end else begin
                sec_ones_d = 4'd0;
                if (sec_tens != 4'd5) begin
                    sec_tens_d = sec_tens + 4'd1;
                end else begin
                    sec_tens_d = 4'd0;
                    if (min_tens == LIM_TENS && min_ones == LIM_ONES) begin
                        min_ones_d = 4'd0;
                        min_tens_d = 4'd0;
                        wrap       = 1'b1;
                    end else if (min_ones != 4'd9) begin
                        min_ones_d = min_ones + 4'd1;
                    end else begin
                        min_ones_d = 4'd0;
                        min_tens_d = min_tens + 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk10) begin
        if (reset) begin
            state_q  <= IDLE;
            ss_q     <= 1'b0;
            sec_ones <= 4'd0;
            sec_tens <= 4'd0;
            min_ones <= 4'd0;
            min_tens <= 4'd0;
            rollover <= 1'b0;
        end else begin
            state_q  <= state_d;
            ss_q     <= start_stop;
            sec_ones <= sec_ones_d;
            sec_tens <= sec_tens_d;
            min_ones <= min_ones_d;
            min_tens <= min_tens_d;
            rollover <= wrap;
        end
    end

`ifdef STOPWATCH_SEG7_EN
    seg7_decoder u_hex0 (.bcd(sec_ones), .seg(hex0));
    seg7_decoder u_hex1 (.bcd(sec_tens), .seg(hex1));
    seg7_decoder u_hex2 (.bcd(min_ones), .seg(hex2));
    seg7_decoder u_hex3 (.bcd(min_tens), .seg(hex3));
`else
    assign hex0 = SEG_BLANK;
    assign hex1 = SEG_BLANK;
    assign hex2 = SEG_BLANK;
    assign hex3 = SEG_BLANK;
`endif

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Self-checking bench for stopwatch_bcd: vector table, directed corner
// sequences and randomized traffic against a seconds-count reference model.
module tb_stopwatch_bcd;

    localparam int MIN_LIMIT  = 59;
    localparam int LIMIT_SECS = (MIN_LIMIT + 1) * 60;

    logic       clk10 = 1'b0;
    logic       reset, clk_enable, start_stop, clear;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       running, rollover;
    logic [6:0] hex0, hex1, hex2, hex3;

    stopwatch_bcd #(.MIN_LIMIT(MIN_LIMIT)) dut (
        .clk10(clk10), .reset(reset), .clk_enable(clk_enable),
        .start_stop(start_stop), .clear(clear),
        .sec_ones(sec_ones), .sec_tens(sec_tens),
        .min_ones(min_ones), .min_tens(min_tens),
        .running(running), .rollover(rollover),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3)
    );

    always #50 clk10 = ~clk10;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: elapsed seconds plus run/pause flags.
    int m_secs  = 0;
    bit m_run   = 0;
    bit m_pause = 0;
    bit m_ssq   = 0;
    bit m_roll  = 0;

    logic [6:0] glyph [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    typedef struct {
        bit          tick;
        bit          ss;
        bit          clr;
        logic [15:0] exp_dig;
        bit          exp_run;
    } vec_t;

    vec_t vec [14];

    function automatic logic [15:0] to_bcd(input int secs);
        int mm = secs / 60;
        int ss = secs % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic [27:0] exp_hex(input logic [15:0] d);
`ifdef STOPWATCH_SEG7_EN
        return {glyph[d[15:12]], glyph[d[11:8]], glyph[d[7:4]], glyph[d[3:0]]};
`else
        return {4{7'h7F}};
`endif
    endfunction

    function automatic logic [15:0] dut_dig();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit t, input bit s, input bit c, input bit r);
        bit rise;
        m_roll = 0;
        if (r) begin
            m_secs = 0; m_run = 0; m_pause = 0; m_ssq = 0;
            return;
        end
        rise = s & ~m_ssq;
        if (m_run) begin
            if (t) begin
                m_secs = m_secs + 1;
                if (m_secs == LIMIT_SECS) begin
                    m_secs = 0;
                    m_roll = 1;
                end
            end
            if (rise) begin m_run = 0; m_pause = 1; end
        end else if (m_pause) begin
            if (rise) begin m_run = 1; m_pause = 0; end
            else if (c) begin m_secs = 0; m_pause = 0; end
        end else if (rise) begin
            m_run = 1;
        end
        m_ssq = s;
    endtask

    task automatic check_model();
        chk("model_digits", 32'(dut_dig()), 32'(to_bcd(m_secs)));
        chk("model_running", 32'(running), 32'(m_run));
        chk("model_rollover", 32'(rollover), 32'(m_roll));
        chk("model_hex", 32'({hex3, hex2, hex1, hex0}), 32'(exp_hex(to_bcd(m_secs))));
    endtask

    task automatic step(input bit t, input bit s, input bit c, input bit r);
        clk_enable = t; start_stop = s; clear = c; reset = r;
        @(posedge clk10);
        model_edge(t, s, c, r);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("reset_digits", 32'(dut_dig()), 32'h0);
        chk("reset_running", 32'(running), 32'h0);
        chk("reset_rollover", 32'(rollover), 32'h0);
    endtask

    initial begin
        bit rs;
        reset = 1'b1; clk_enable = 1'b0; start_stop = 1'b0; clear = 1'b0;

        vec[0]  = '{1, 0, 0, 16'h0000, 0};
        vec[1]  = '{1, 1, 0, 16'h0000, 1};
        vec[2]  = '{1, 1, 0, 16'h0001, 1};
        vec[3]  = '{0, 0, 0, 16'h0001, 1};
        vec[4]  = '{1, 0, 1, 16'h0002, 1};
        vec[5]  = '{1, 1, 0, 16'h0003, 0};
        vec[6]  = '{1, 1, 0, 16'h0003, 0};
        vec[7]  = '{0, 0, 0, 16'h0003, 0};
        vec[8]  = '{0, 1, 1, 16'h0003, 1};
        vec[9]  = '{1, 0, 0, 16'h0004, 1};
        vec[10] = '{0, 1, 0, 16'h0004, 0};
        vec[11] = '{1, 0, 1, 16'h0000, 0};
        vec[12] = '{1, 0, 0, 16'h0000, 0};
        vec[13] = '{0, 1, 0, 16'h0000, 1};

        // Reset, then ticks without start.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("idle_digits", 32'(dut_dig()), 32'h0);
        chk("idle_running", 32'(running), 32'h0);
`ifdef STOPWATCH_SEG7_EN
        chk("idle_hex0", 32'(hex0), 32'h40);
`else
        chk("idle_hex0", 32'(hex0), 32'h7F);
`endif

        // Start, 61 ticks -> 01:01.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 61; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t61_digits", 32'(dut_dig()), 32'h0101);
        chk("t61_running", 32'(running), 32'h1);
`ifdef STOPWATCH_SEG7_EN
        chk("t61_hex1", 32'(hex1), 32'h40);
        chk("t61_hex0", 32'(hex0), 32'h79);
`endif

        // Run on to 59:59, then wrap.
        for (int i = 0; i < LIMIT_SECS - 1 - 61; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("max_digits", 32'(dut_dig()), 32'h5959);
        chk("max_rollover", 32'(rollover), 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("wrap_digits", 32'(dut_dig()), 32'h0000);
        chk("wrap_rollover", 32'(rollover), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("wrap_rollover_drop", 32'(rollover), 32'h0);

        // Start, 5 ticks, stop, 3 ticks, clear; then clear while running.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("pause_digits", 32'(dut_dig()), 32'h0005);
        chk("pause_running", 32'(running), 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("clear_digits", 32'(dut_dig()), 32'h0000);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("clear_idle_hold", 32'(dut_dig()), 32'h0000);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("run_clear_digits", 32'(dut_dig()), 32'h0007);
        chk("run_clear_running", 32'(running), 32'h1);

        // Start coincident with tick from IDLE.
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("coinc_digits", 32'(dut_dig()), 32'h0000);
        chk("coinc_running", 32'(running), 32'h1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("coinc_next", 32'(dut_dig()), 32'h0001);

        // Held start_stop with ticks -> one toggle; 99 counted ticks.
        do_reset();
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("hold_digits", 32'(dut_dig()), 32'h0139);
        chk("hold_running", 32'(running), 32'h1);

        // Reset mid-count at 00:42.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 42; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("pre_reset_digits", 32'(dut_dig()), 32'h0042);
        do_reset();
        chk("mid_reset_running", 32'(running), 32'h0);

        // Vector table.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            step(vec[i].tick, vec[i].ss, vec[i].clr, 1'b0);
            chk($sformatf("vec%0d_digits", i), 32'(dut_dig()), 32'(vec[i].exp_dig));
            chk($sformatf("vec%0d_running", i), 32'(running), 32'(vec[i].exp_run));
        end

        // Randomized traffic against the model.
        do_reset();
        rs = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) rs = ~rs;
            step(1'($urandom_range(0, 1)), rs,
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 299) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
